// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage hazard detection built on a per-register pending-write
//   scoreboard. Each architectural register has a small countdown of cycles
//   until its value is forwardable into EX. Loads, multiplies and the
//   variable-latency divider are all tracked this way. The block also
//   produces the pipeline flush mask and a saturating count of hazard stalls.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   IF/ID holds a valid instruction
//   id_is_branch               ID instruction resolves in ID (operands needed at ID)
//   id_rs1/id_rs2              source registers; id_use_rs1/id_use_rs2 qualify them
//   id_reg_write, id_rd        destination write enable and index
//   id_class                   0=ALU, 1=LOAD, 2=MUL, 3=DIV
//   div_done, div_rd           divider result forwardable this cycle, and its rd
//   redirect_ex, redirect_id   control-flow redirects resolved in EX / ID
//   inst_mem_wait, data_mem_wait  memory not ready
//   hazard_stall               hold PC and IF/ID, bubble into ID/EX
//   mem_stall                  freeze all stages
//   flush_mask                 per-pipeline-register flush, bit0 = IF/ID
//   div_busy                   a divide is outstanding
//   stall_cycles               saturating count of hazard_stall cycles

module hazard_scoreboard #(
    parameter int NUM_STAGES = 5,
    parameter int ID_STAGE   = 1,
    parameter int EX_STAGE   = 2,
    parameter int LOAD_LAT   = 2,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_is_branch,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_reg_write,
    input  logic [4:0]            id_rd,
    input  logic [1:0]            id_class,
    input  logic                  div_done,
    input  logic [4:0]            div_rd,
    input  logic                  redirect_ex,
    input  logic                  redirect_id,
    input  logic                  inst_mem_wait,
    input  logic                  data_mem_wait,
    output logic                  hazard_stall,
    output logic                  mem_stall,
    output logic [NUM_STAGES-1:0] flush_mask,
    output logic                  div_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    // Counter width must hold the longest fixed latency plus a distinct
    // all-ones sentinel that marks "waiting on the divider".
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 2);

    localparam logic [CW-1:0] SENTINEL = '1;
    localparam logic [1:0]    CLS_ALU  = 2'd0;
    localparam logic [1:0]    CLS_LOAD = 2'd1;
    localparam logic [1:0]    CLS_MUL  = 2'd2;
    localparam logic [1:0]    CLS_DIV  = 2'd3;

    logic [CW-1:0] cnt [32];
    logic          div_pend;
    logic [4:0]    div_rd_q;

    logic          src_hazard;
    logic          struct_hazard;
    logic          waw_hazard;
    logic          issue;
    logic          issue_wr;
    logic          div_cpl;
    logic [CW-1:0] issue_val;

    // A value with count 1 reaches EX through the forwarding path just in
    // time for a normal instruction, but a branch reads it a stage earlier.
    function automatic logic src_stall(input logic          use_s,
                                       input logic [4:0]    s,
                                       input logic [CW-1:0] c,
                                       input logic          br);
        return use_s && (s != 5'd0) && (br ? (c != '0) : (c > CW'(1)));
    endfunction

    always_comb begin
        src_hazard    = src_stall(id_use_rs1, id_rs1, cnt[id_rs1], id_is_branch) ||
                        src_stall(id_use_rs2, id_rs2, cnt[id_rs2], id_is_branch);
        struct_hazard = (id_class == CLS_DIV) && div_pend;
        // Evaluated on registered div_pend, so it still stalls in the cycle
        // div_done arrives; costs one bubble but keeps the path short.
        waw_hazard    = id_reg_write && div_pend && (id_rd == div_rd_q);
        hazard_stall  = id_valid && (src_hazard || struct_hazard || waw_hazard);
        mem_stall     = inst_mem_wait || data_mem_wait;

        issue    = id_valid && !hazard_stall && !mem_stall && !redirect_ex;
        issue_wr = issue && id_reg_write && (id_rd != 5'd0);
        div_cpl  = div_done && div_pend && (div_rd == div_rd_q);

        case (id_class)
            CLS_ALU:  issue_val = CW'(1);
            CLS_LOAD: issue_val = CW'(LOAD_LAT);
            CLS_MUL:  issue_val = CW'(MUL_LAT);
            default:  issue_val = SENTINEL;
        endcase
    end

    always_comb begin
        flush_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (redirect_ex) begin
                flush_mask[i] = (i < EX_STAGE);
            end else if (redirect_id && !hazard_stall) begin
                flush_mask[i] = (i < ID_STAGE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            div_pend     <= 1'b0;
            div_rd_q     <= 5'd0;
            stall_cycles <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (issue_wr && (id_rd == 5'(r))) begin
                    cnt[r] <= issue_val;
                end else if (div_cpl && (div_rd == 5'(r))) begin
                    cnt[r] <= CW'(1);
                end else if (!mem_stall && (cnt[r] != '0) && (cnt[r] != SENTINEL)) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end

            if (div_cpl) begin
                div_pend <= 1'b0;
            end
            if (issue_wr && (id_class == CLS_DIV)) begin
                div_pend <= 1'b1;
                div_rd_q <= id_rd;
            end

            if (hazard_stall && !mem_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign div_busy = div_pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard, built with CNT_W = 4 so the
// stall counter saturation is reachable in a short run.

module tb_hazard_scoreboard;

    localparam int NUM_STAGES = 5;
    localparam int CNT_W      = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  id_valid;
    logic                  id_is_branch;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_reg_write;
    logic [4:0]            id_rd;
    logic [1:0]            id_class;
    logic                  div_done;
    logic [4:0]            div_rd;
    logic                  redirect_ex;
    logic                  redirect_id;
    logic                  inst_mem_wait;
    logic                  data_mem_wait;
    logic                  hazard_stall;
    logic                  mem_stall;
    logic [NUM_STAGES-1:0] flush_mask;
    logic                  div_busy;
    logic [CNT_W-1:0]      stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .NUM_STAGES(NUM_STAGES),
        .ID_STAGE  (1),
        .EX_STAGE  (2),
        .LOAD_LAT  (2),
        .MUL_LAT   (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_is_branch (id_is_branch),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_reg_write (id_reg_write),
        .id_rd        (id_rd),
        .id_class     (id_class),
        .div_done     (div_done),
        .div_rd       (div_rd),
        .redirect_ex  (redirect_ex),
        .redirect_id  (redirect_id),
        .inst_mem_wait(inst_mem_wait),
        .data_mem_wait(data_mem_wait),
        .hazard_stall (hazard_stall),
        .mem_stall    (mem_stall),
        .flush_mask   (flush_mask),
        .div_busy     (div_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic br, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic wr, input logic [4:0] rd, input logic [1:0] cls);
        id_valid     = 1'b1;
        id_is_branch = br;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_reg_write = wr;
        id_rd        = rd;
        id_class     = cls;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
        id_rs1       = 5'd0;
        id_use_rs1   = 1'b0;
        id_rs2       = 5'd0;
        id_use_rs2   = 1'b0;
        id_reg_write = 1'b0;
        id_rd        = 5'd0;
        id_class     = 2'd0;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        div_done      = 1'b0;
        div_rd        = 5'd0;
        redirect_ex   = 1'b0;
        redirect_id   = 1'b0;
        inst_mem_wait = 1'b0;
        data_mem_wait = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_div_busy", 32'(div_busy), 32'd0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        check("rst_flush", 32'(flush_mask), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        rst_n = 1'b1;
        tick();

        // LOAD x5 ; ADD x6,x5,x1 -> one bubble
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 2'd1);
        #1 check("ld_issue", 32'(hazard_stall), 32'd0);
        tick();
        set_id(0, 5'd5, 1, 5'd1, 1, 1, 5'd6, 2'd0);
        #1 check("ld_use_c1", 32'(hazard_stall), 32'd1);
        tick();
        check("ld_use_c2", 32'(hazard_stall), 32'd0);
        tick();
        check("ld_use_cnt", 32'(stall_cycles), 32'd1);
        idle();
        tick();
        tick();

        // ADD x7 ; BEQ x7,x0 -> one bubble
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd0);
        tick();
        set_id(1, 5'd7, 1, 5'd0, 1, 0, 5'd0, 2'd0);
        #1 check("alu_br_c1", 32'(hazard_stall), 32'd1);
        tick();
        check("alu_br_c2", 32'(hazard_stall), 32'd0);
        tick();

        // LOAD x7 ; BEQ x7 -> two bubbles
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd1);
        tick();
        set_id(1, 5'd7, 1, 5'd0, 1, 0, 5'd0, 2'd0);
        #1 check("ld_br_c1", 32'(hazard_stall), 32'd1);
        tick();
        check("ld_br_c2", 32'(hazard_stall), 32'd1);
        tick();
        check("ld_br_c3", 32'(hazard_stall), 32'd0);
        tick();
        check("br_cnt", 32'(stall_cycles), 32'd4);

        // LOAD x0 ; BEQ x0,x0 -> x0 never stalls
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 2'd1);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 2'd0);
        #1 check("x0_no_stall", 32'(hazard_stall), 32'd0);
        tick();

        // MUL x3 ; ADD x4,x3 -> two bubbles
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd3, 2'd2);
        tick();
        set_id(0, 5'd3, 1, 5'd0, 0, 1, 5'd4, 2'd0);
        #1 check("mul_c1", 32'(hazard_stall), 32'd1);
        tick();
        check("mul_c2", 32'(hazard_stall), 32'd1);
        tick();
        check("mul_c3", 32'(hazard_stall), 32'd0);
        tick();
        idle();
        tick();

        // MUL x3 again, with data_mem_wait held 4 cycles mid-stall
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd3, 2'd2);
        tick();
        set_id(0, 5'd3, 1, 5'd0, 0, 1, 5'd4, 2'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            data_mem_wait = (i >= 1 && i <= 4);
            #1;
            if (i == 2) check("mem_stall_on", 32'(mem_stall), 32'd1);
            if (!hazard_stall) break;
            n++;
            tick();
        end
        data_mem_wait = 1'b0;
        check("mul_mem_len", 32'(n), 32'd6);
        tick();
        check("mul_mem_cnt", 32'(stall_cycles), 32'd8);
        idle();
        tick();

        // DIV x9 ; ADD x4,x9 stalls until div_done, released one cycle later
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd3);
        tick();
        check("div_busy_set", 32'(div_busy), 32'd1);
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd10, 2'd3);
        #1 check("div_struct", 32'(hazard_stall), 32'd1);
        set_id(0, 5'd1, 1, 5'd2, 1, 1, 5'd9, 2'd0);
        #1 check("div_waw", 32'(hazard_stall), 32'd1);
        set_id(0, 5'd9, 1, 5'd0, 0, 1, 5'd4, 2'd0);
        #1 check("div_use_c1", 32'(hazard_stall), 32'd1);
        tick();
        check("div_use_c2", 32'(hazard_stall), 32'd1);
        div_done = 1'b1;
        div_rd   = 5'd9;
        set_id(0, 5'd1, 1, 5'd2, 1, 1, 5'd9, 2'd0);
        #1 check("div_waw_done", 32'(hazard_stall), 32'd1);
        set_id(0, 5'd9, 1, 5'd0, 0, 1, 5'd4, 2'd0);
        #1 check("div_use_done", 32'(hazard_stall), 32'd1);
        tick();
        div_done = 1'b0;
        check("div_busy_clr", 32'(div_busy), 32'd0);
        check("div_release", 32'(hazard_stall), 32'd0);
        tick();
        check("div_cnt", 32'(stall_cycles), 32'd10);
        idle();
        tick();

        // div_done with nothing pending is ignored
        div_done = 1'b1;
        div_rd   = 5'd9;
        tick();
        div_done = 1'b0;
        set_id(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        #1 check("div_spurious", 32'(hazard_stall), 32'd0);
        check("div_spur_busy", 32'(div_busy), 32'd0);
        tick();

        // Flush priority
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd12, 2'd0);
        redirect_ex = 1'b1;
        redirect_id = 1'b1;
        #1 check("flush_both", 32'(flush_mask), 32'b00011);
        tick();
        redirect_ex = 1'b0;
        redirect_id = 1'b0;
        set_id(1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        #1 check("flush_no_issue", 32'(hazard_stall), 32'd0);
        redirect_id = 1'b1;
        #1 check("flush_id", 32'(flush_mask), 32'b00001);
        redirect_id = 1'b0;
        tick();
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd13, 2'd1);
        tick();
        set_id(1, 5'd13, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        redirect_id = 1'b1;
        #1 check("flush_id_stall", 32'(flush_mask), 32'b00000);
        check("flush_id_hz", 32'(hazard_stall), 32'd1);
        redirect_ex = 1'b1;
        #1 check("flush_ex_stall", 32'(flush_mask), 32'b00011);
        redirect_ex = 1'b0;
        redirect_id = 1'b0;
        idle();
        tick();
        tick();
        tick();

        // Asynchronous reset with a divide outstanding
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd3);
        tick();
        check("rdiv_busy", 32'(div_busy), 32'd1);
        set_id(0, 5'd9, 1, 5'd0, 0, 1, 5'd4, 2'd0);
        #1 check("rdiv_stall", 32'(hazard_stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rdiv_busy_clr", 32'(div_busy), 32'd0);
        check("rdiv_no_stall", 32'(hazard_stall), 32'd0);
        check("rdiv_cnt_clr", 32'(stall_cycles), 32'd0);
        tick();
        rst_n = 1'b1;
        div_done = 1'b1;
        div_rd   = 5'd9;
        set_id(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 2'd0);
        tick();
        div_done = 1'b0;
        #1 check("rdiv_late_done", 32'(hazard_stall), 32'd0);
        check("rdiv_late_busy", 32'(div_busy), 32'd0);
        tick();

        // Saturation of stall_cycles at CNT_W = 4
        set_id(0, 5'd0, 0, 5'd0, 0, 1, 5'd16, 2'd3);
        tick();
        set_id(0, 5'd16, 1, 5'd0, 0, 1, 5'd17, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat_mid", 32'(stall_cycles), 32'd14);
        end
        check("sat_hold", 32'(stall_cycles), 32'd15);
        check("sat_still_stall", 32'(hazard_stall), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
